ring_decoder: RTL and testbench
===============================

Name: ring_decoder

Overview:
- Receive side of the one-hot ring-counter interface: samples a rotating one-hot code and converts it to a binary position.
- Checks that each sample is legal one-hot and is the rotate-left successor of the previous one.
- Acquires and holds lock with a flywheel, counts completed laps, and reports errors.
- Sits downstream of any ring-counter-driven sequencer, as its monitor/decoder.

Parameters:
- WIDTH, 8, ring length in bits (≥2); index width IW = $clog2(WIDTH).
- LOCK_CNT, 2, consecutive correct successor steps needed to enter LOCKED (≥1).
- ERR_MAX, 3, consecutive bad samples in LOCKED that force a return to HUNT (≥1).
- LAP_W, 8, lap counter width.
- ERR_W, 8, saturating error counter width.

Ports:
- clk  in  1  sole clock; all state on posedge.
- rst_n  in  1  reset, asynchronous, active-low.
- clear  in  1  synchronous clear: to HUNT, counters zeroed.
- in_valid  in  1  in_code is meaningful this cycle.
- in_code  in  WIDTH  one-hot ring sample.
- out_valid  out  1  out_index valid (legal code sampled).
- out_index  out  IW  binary position of the set bit.
- locked  out  1  state == LOCKED.
- code_err  out  1  one-cycle pulse: sampled code not one-hot.
- step_err  out  1  one-cycle pulse: legal code, but not the expected successor while in SYNC or LOCKED.
- lap_count  out  LAP_W  laps completed while locked; wraps modulo 2^LAP_W.
- err_count  out  ERR_W  total code_err + step_err events; saturates at all-ones.

Behaviour:
- Reset (rst_n low, asynchronous): state HUNT; all outputs 0; prev index, match count and miss count 0.
- Latency: all outputs are registered, 1 cycle after the in_valid sample. Cycles with in_valid=0 change nothing; output pulses drop to 0.
- Legal code: exactly one bit set. Bit i maps to index i; index 0 is the LSB.
- Successor of index i is (i+1) mod WIDTH, matching rotate-left 10000000→00000001.
- The same code repeated on consecutive valid samples counts as a wrong step.
- out_valid = in_valid & legal. out_index holds its last value when out_valid=0.
- HUNT:
  - legal sample → prev=idx, match=0, go to SYNC.
  - illegal sample → code_err.
  - No step_err is raised in HUNT.
- SYNC:
  - legal successor → match+1, prev=idx; when match+1 == LOCK_CNT, go to LOCKED.
  - legal non-successor → step_err, prev=idx, match=0, stay in SYNC.
  - illegal → code_err, go to HUNT.
- LOCKED:
  - expected = prev+1 mod WIDTH.
  - Correct sample → prev=idx, miss=0. If prev==WIDTH-1 (step WIDTH-1→0), lap_count+1.
  - Bad sample (illegal or wrong) → matching err pulse, miss+1, prev=expected (flywheel keeps turning). A flywheel step through WIDTH-1→0 does not count a lap.
  - When miss+1 == ERR_MAX, go to HUNT and clear miss.
- err_count increments once per error pulse and saturates; code_err and step_err are mutually exclusive.
- clear:
  - Has priority over the sample in the same cycle (that sample is dropped).
  - Goes to HUNT; lap_count, err_count, match and miss = 0; pulses and out_valid = 0.
- Reset mid-operation returns everything to the reset values immediately.

Decomposition:
- Shared package ring_pkg holds:
  - state enum {HUNT, SYNC, LOCKED};
  - function onehot_to_idx(code) returning {legal, idx};
  - function next_idx(idx, WIDTH).
- One natural sub-module: onehot_check, a combinational legality check plus priority-free index encode. It is reusable by the ring-counter self-checks.
- FSM and counters stay in ring_decoder.

Test Plan (WIDTH=8, LOCK_CNT=2, ERR_MAX=3):
- Lock: after reset, feed 80,01,02,04 on consecutive cycles → out_index 7,0,1,2 one cycle late; locked rises the cycle after 02 is sampled; no errors.
- Laps: locked, feed two full rotations 01..80, then 01 → lap_count 0→1 on the first 80→01 step and 1→2 on the second; err_count stays 0.
- Illegal: locked at index 2, feed 03 → code_err pulse, out_valid=0, err_count=1, locked stays 1. Feed 00, then 81 → after the third bad sample locked=0 (HUNT), err_count=3.
- Flywheel: locked at index 2, feed 10 → step_err (expected 3, flywheel prev=3); then feed 10 → accepted (successor of 3 is 4), miss cleared, no pulse.
- Gaps/repeat: locked, in_valid low for 5 cycles then the correct successor → no error; the same code on two valid samples → step_err.
- Control: drive clear with a valid 01 → HUNT, counters 0, out_valid 0. Deassert rst_n asynchronously mid-rotation → all outputs 0 before the next clk edge.

Source files
------------

// File: rtl/ring_decoder_pkg.sv
// Shared types and helpers for the one-hot ring decoder.
// - state_t        : decoder FSM states (HUNT, SYNC, LOCKED)
// - dec_t          : {legal, idx} result of a one-hot decode
// - onehot_to_idx  : legality check plus priority-free index encode
// - next_idx       : ring successor (idx + 1) mod width
// Helpers operate on MAX_W-bit codes; narrower rings zero-extend.
package ring_pkg;

    localparam int unsigned MAX_W  = 64;
    localparam int unsigned MAX_IW = 7;

    localparam logic [1:0] ST_HUNT   = 2'd0;
    localparam logic [1:0] ST_SYNC   = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    typedef enum logic [1:0] {
        HUNT   = ST_HUNT,
        SYNC   = ST_SYNC,
        LOCKED = ST_LOCKED
    } state_t;

    typedef struct packed {
        logic              legal;
        logic [MAX_IW-1:0] idx;
    } dec_t;

    // Index is the OR of the positions of all set bits; it is only
    // meaningful when exactly one bit is set, so no priority chain.
    function automatic dec_t onehot_to_idx(input logic [MAX_W-1:0] code);
        dec_t        r;
        int unsigned ones;
        r.idx = '0;
        ones  = 0;
        for (int unsigned i = 0; i < MAX_W; i++) begin
            if (code[i]) begin
                r.idx = r.idx | MAX_IW'(i);
                ones++;
            end
        end
        r.legal = (ones == 1);
        return r;
    endfunction

    function automatic logic [MAX_IW-1:0] next_idx(input logic [MAX_IW-1:0] idx,
                                                   input int unsigned       width);
        if (32'(idx) == width - 1)
            return '0;
        else
            return idx + MAX_IW'(1);
    endfunction

endpackage

// File: rtl/ring_decoder_if.sv
// Sample channel from a ring-counter source into the decoder.
// - in_valid : in_code is meaningful this cycle
// - in_code  : one-hot ring sample, WIDTH bits
// master drives the sample, slave (the decoder) receives it.
interface ring_decoder_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic [WIDTH-1:0] in_code;

    modport master (output in_valid, output in_code);
    modport slave  (input  in_valid, input  in_code);
endinterface

// File: rtl/ring_decoder_onehot_check.sv
// Combinational one-hot legality check and index encode.
// - code  : WIDTH-bit sample
// - legal : exactly one bit set
// - idx   : position of the set bit (undefined when !legal)
module onehot_check
    import ring_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    localparam int unsigned IW   = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] code,
    output logic             legal,
    output logic [IW-1:0]    idx
);

    dec_t d;
    logic unused_hi;

    always_comb begin
        d     = onehot_to_idx(MAX_W'(code));
        legal = d.legal;
        idx   = d.idx[IW-1:0];
    end

    // Upper index bits are always zero for a ring of WIDTH bits.
    assign unused_hi = ^d.idx[MAX_IW-1:IW];

endmodule

// File: rtl/ring_decoder.sv
// Receive-side monitor/decoder for a rotating one-hot ring code.
// Ports:
// - clk, rst_n   : clock, asynchronous active-low reset
// - clear        : synchronous clear to HUNT, counters zeroed
// - rx           : ring_decoder_if.slave (in_valid, in_code)
// - out_valid    : legal code sampled last cycle
// - out_index    : binary position of last legal code (holds otherwise)
// - locked       : FSM is in LOCKED
// - code_err     : pulse, sample was not one-hot
// - step_err     : pulse, legal sample but not the expected successor
// - lap_count    : laps completed while locked (wraps)
// - err_count    : total error pulses (saturates)
module ring_decoder
    import ring_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned LOCK_CNT = 2,
    parameter int unsigned ERR_MAX  = 3,
    parameter int unsigned LAP_W    = 8,
    parameter int unsigned ERR_W    = 8,
    localparam int unsigned IW      = $clog2(WIDTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    ring_decoder_if.slave     rx,
    output logic              out_valid,
    output logic [IW-1:0]     out_index,
    output logic              locked,
    output logic              code_err,
    output logic              step_err,
    output logic [LAP_W-1:0]  lap_count,
    output logic [ERR_W-1:0]  err_count
);

    localparam int unsigned MW = $clog2(LOCK_CNT + 1);
    localparam int unsigned EW = $clog2(ERR_MAX + 1);

    state_t             state;
    logic [IW-1:0]      prev;
    logic [MW-1:0]      match;
    logic [EW-1:0]      miss;

    logic               legal;
    logic [IW-1:0]      idx;
    logic [MAX_IW-1:0]  exp_wide;
    logic [IW-1:0]      expected;
    logic               unused_exp;
    logic               bad_code;
    logic               bad_step;
    logic               err_evt;

    onehot_check #(.WIDTH(WIDTH)) u_chk (
        .code  (rx.in_code),
        .legal (legal),
        .idx   (idx)
    );

    assign exp_wide   = next_idx(MAX_IW'(prev), WIDTH);
    assign expected   = exp_wide[IW-1:0];
    assign unused_exp = ^exp_wide[MAX_IW-1:IW];

    // HUNT never reports a step error; it has no reference position yet.
    assign bad_code = !legal;
    assign bad_step = legal && (state != HUNT) && (idx != expected);
    assign err_evt  = rx.in_valid && (bad_code || bad_step);

    assign locked = (state == LOCKED);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= HUNT;
            prev      <= '0;
            match     <= '0;
            miss      <= '0;
            out_valid <= 1'b0;
            out_index <= '0;
            code_err  <= 1'b0;
            step_err  <= 1'b0;
            lap_count <= '0;
            err_count <= '0;
        end else begin
            out_valid <= 1'b0;
            code_err  <= 1'b0;
            step_err  <= 1'b0;
            if (clear) begin
                state     <= HUNT;
                match     <= '0;
                miss      <= '0;
                lap_count <= '0;
                err_count <= '0;
            end else if (rx.in_valid) begin
                out_valid <= legal;
                if (legal)
                    out_index <= idx;
                if (err_evt && (err_count != '1))
                    err_count <= err_count + ERR_W'(1);
                unique case (state)
                    HUNT: begin
                        if (legal) begin
                            prev  <= idx;
                            match <= '0;
                            state <= SYNC;
                        end else begin
                            code_err <= 1'b1;
                        end
                    end
                    SYNC: begin
                        if (!legal) begin
                            code_err <= 1'b1;
                            state    <= HUNT;
                        end else if (idx == expected) begin
                            prev  <= idx;
                            match <= match + MW'(1);
                            if (32'(match) + 1 == LOCK_CNT)
                                state <= LOCKED;
                        end else begin
                            step_err <= 1'b1;
                            prev     <= idx;
                            match    <= '0;
                        end
                    end
                    LOCKED: begin
                        if (legal && (idx == expected)) begin
                            prev <= idx;
                            miss <= '0;
                            if (32'(prev) == WIDTH - 1)
                                lap_count <= lap_count + LAP_W'(1);
                        end else begin
                            // Flywheel: advance as if the expected code had arrived.
                            code_err <= bad_code;
                            step_err <= bad_step;
                            prev     <= expected;
                            if (32'(miss) + 1 == ERR_MAX) begin
                                state <= HUNT;
                                miss  <= '0;
                            end else begin
                                miss <= miss + EW'(1);
                            end
                        end
                    end
                    default: state <= HUNT;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ring_decoder.sv
module tb_ring_decoder;

    logic       clk;
    logic       rst_n;
    logic       clear;
    logic       out_valid;
    logic [2:0] out_index;
    logic       locked;
    logic       code_err;
    logic       step_err;
    logic [7:0] lap_count;
    logic [7:0] err_count;

    int tests_run;
    int tests_failed;

    ring_decoder_if #(.WIDTH(8)) bus ();

    ring_decoder #(
        .WIDTH    (8),
        .LOCK_CNT (2),
        .ERR_MAX  (3),
        .LAP_W    (8),
        .ERR_W    (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .rx        (bus),
        .out_valid (out_valid),
        .out_index (out_index),
        .locked    (locked),
        .code_err  (code_err),
        .step_err  (step_err),
        .lap_count (lap_count),
        .err_count (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle at the falling edge, then settle 1 time unit past the rising edge.
    task automatic cyc(input logic clr, input logic v, input logic [7:0] c);
        @(negedge clk);
        clear        = clr;
        bus.in_valid = v;
        bus.in_code  = c;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clear = 1'b0; bus.in_valid = 1'b0; bus.in_code = '0;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if ({out_valid, out_index, locked, code_err, step_err, lap_count, err_count} !== 23'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %b/%0d/%b/%b/%b/%0d/%0d required all zero",
                     out_valid, out_index, locked, code_err, step_err, lap_count, err_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_lock();
        logic [7:0] codes [4];
        logic [2:0] idxs  [4];
        logic       lks   [4];
        codes = '{8'h80, 8'h01, 8'h02, 8'h04};
        idxs  = '{3'd7, 3'd0, 3'd1, 3'd2};
        lks   = '{1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b1, codes[i]);
            tests_run++;
            if ({out_valid, out_index, locked, code_err, step_err} !== {1'b1, idxs[i], lks[i], 2'b00}) begin
                tests_failed++;
                $display("FAIL lock_step%0d: got v=%b idx=%0d lk=%b ce=%b se=%b required v=1 idx=%0d lk=%b ce=0 se=0",
                         i, out_valid, out_index, locked, code_err, step_err, idxs[i], lks[i]);
            end
        end
    endtask

    task automatic test_laps();
        for (int k = 3; k < 8; k++) cyc(1'b0, 1'b1, 8'd1 << k);
        tests_run++;
        if (lap_count !== 8'd0) begin
            tests_failed++;
            $display("FAIL lap_before_wrap: got %0d required 0", lap_count);
        end
        cyc(1'b0, 1'b1, 8'h01);
        tests_run++;
        if (lap_count !== 8'd1) begin
            tests_failed++;
            $display("FAIL lap_first: got %0d required 1", lap_count);
        end
        for (int k = 1; k < 8; k++) cyc(1'b0, 1'b1, 8'd1 << k);
        tests_run++;
        if (lap_count !== 8'd1) begin
            tests_failed++;
            $display("FAIL lap_mid: got %0d required 1", lap_count);
        end
        cyc(1'b0, 1'b1, 8'h01);
        tests_run++;
        if ({lap_count, err_count, locked} !== {8'd2, 8'd0, 1'b1}) begin
            tests_failed++;
            $display("FAIL lap_second: got lap=%0d err=%0d lk=%b required lap=2 err=0 lk=1",
                     lap_count, err_count, locked);
        end
    endtask

    task automatic test_illegal();
        cyc(1'b0, 1'b1, 8'h02);
        cyc(1'b0, 1'b1, 8'h04);
        cyc(1'b0, 1'b1, 8'h03);
        tests_run++;
        if ({code_err, step_err, out_valid, out_index, err_count, locked} !== {1'b1, 1'b0, 1'b0, 3'd2, 8'd1, 1'b1}) begin
            tests_failed++;
            $display("FAIL illegal_first: got ce=%b se=%b v=%b idx=%0d err=%0d lk=%b required ce=1 se=0 v=0 idx=2 err=1 lk=1",
                     code_err, step_err, out_valid, out_index, err_count, locked);
        end
        cyc(1'b0, 1'b1, 8'h00);
        tests_run++;
        if ({code_err, err_count, locked} !== {1'b1, 8'd2, 1'b1}) begin
            tests_failed++;
            $display("FAIL illegal_second: got ce=%b err=%0d lk=%b required ce=1 err=2 lk=1",
                     code_err, err_count, locked);
        end
        cyc(1'b0, 1'b1, 8'h81);
        tests_run++;
        if ({code_err, err_count, locked, out_index} !== {1'b1, 8'd3, 1'b0, 3'd2}) begin
            tests_failed++;
            $display("FAIL illegal_unlock: got ce=%b err=%0d lk=%b idx=%0d required ce=1 err=3 lk=0 idx=2",
                     code_err, err_count, locked, out_index);
        end
    endtask

    task automatic test_flywheel();
        cyc(1'b0, 1'b1, 8'h01);
        cyc(1'b0, 1'b1, 8'h02);
        cyc(1'b0, 1'b1, 8'h04);
        tests_run++;
        if (locked !== 1'b1) begin
            tests_failed++;
            $display("FAIL fly_relock: got lk=%b required 1", locked);
        end
        cyc(1'b0, 1'b1, 8'h10);
        tests_run++;
        if ({step_err, code_err, out_valid, out_index, err_count, locked} !== {1'b1, 1'b0, 1'b1, 3'd4, 8'd4, 1'b1}) begin
            tests_failed++;
            $display("FAIL fly_wrong: got se=%b ce=%b v=%b idx=%0d err=%0d lk=%b required se=1 ce=0 v=1 idx=4 err=4 lk=1",
                     step_err, code_err, out_valid, out_index, err_count, locked);
        end
        cyc(1'b0, 1'b1, 8'h10);
        tests_run++;
        if ({step_err, code_err, err_count, locked} !== {1'b0, 1'b0, 8'd4, 1'b1}) begin
            tests_failed++;
            $display("FAIL fly_accept: got se=%b ce=%b err=%0d lk=%b required se=0 ce=0 err=4 lk=1",
                     step_err, code_err, err_count, locked);
        end
        // Two further misses must not unlock if the accept above cleared miss.
        cyc(1'b0, 1'b1, 8'h10);
        cyc(1'b0, 1'b1, 8'h10);
        tests_run++;
        if ({step_err, err_count, locked} !== {1'b1, 8'd6, 1'b1}) begin
            tests_failed++;
            $display("FAIL fly_miss_cleared: got se=%b err=%0d lk=%b required se=1 err=6 lk=1",
                     step_err, err_count, locked);
        end
        cyc(1'b0, 1'b1, 8'h80);
        cyc(1'b0, 1'b1, 8'h01);
        tests_run++;
        if ({lap_count, locked, step_err} !== {8'd3, 1'b1, 1'b0}) begin
            tests_failed++;
            $display("FAIL fly_recover_lap: got lap=%0d lk=%b se=%b required lap=3 lk=1 se=0",
                     lap_count, locked, step_err);
        end
        for (int k = 1; k < 7; k++) cyc(1'b0, 1'b1, 8'd1 << k);
        // Prev=6: two misses flywheel through 7 and 0; no lap may be counted.
        cyc(1'b0, 1'b1, 8'h40);
        cyc(1'b0, 1'b1, 8'h40);
        cyc(1'b0, 1'b1, 8'h02);
        tests_run++;
        if ({lap_count, err_count, locked, step_err, out_index} !== {8'd3, 8'd8, 1'b1, 1'b0, 3'd1}) begin
            tests_failed++;
            $display("FAIL fly_wrap_nolap: got lap=%0d err=%0d lk=%b se=%b idx=%0d required lap=3 err=8 lk=1 se=0 idx=1",
                     lap_count, err_count, locked, step_err, out_index);
        end
    endtask

    task automatic test_gaps();
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 1'b0, 8'hFF);
            tests_run++;
            if ({out_valid, code_err, step_err, out_index, err_count} !== {3'b000, 3'd1, 8'd8}) begin
                tests_failed++;
                $display("FAIL gap_idle%0d: got v=%b ce=%b se=%b idx=%0d err=%0d required v=0 ce=0 se=0 idx=1 err=8",
                         i, out_valid, code_err, step_err, out_index, err_count);
            end
        end
        cyc(1'b0, 1'b1, 8'h04);
        tests_run++;
        if ({out_valid, out_index, code_err, step_err, err_count} !== {1'b1, 3'd2, 2'b00, 8'd8}) begin
            tests_failed++;
            $display("FAIL gap_resume: got v=%b idx=%0d ce=%b se=%b err=%0d required v=1 idx=2 ce=0 se=0 err=8",
                     out_valid, out_index, code_err, step_err, err_count);
        end
        cyc(1'b0, 1'b1, 8'h04);
        tests_run++;
        if ({step_err, code_err, err_count} !== {1'b1, 1'b0, 8'd9}) begin
            tests_failed++;
            $display("FAIL gap_repeat: got se=%b ce=%b err=%0d required se=1 ce=0 err=9",
                     step_err, code_err, err_count);
        end
        cyc(1'b0, 1'b1, 8'h10);
        tests_run++;
        if ({step_err, locked, out_index} !== {1'b0, 1'b1, 3'd4}) begin
            tests_failed++;
            $display("FAIL gap_after_repeat: got se=%b lk=%b idx=%0d required se=0 lk=1 idx=4",
                     step_err, locked, out_index);
        end
    endtask

    task automatic test_clear();
        cyc(1'b1, 1'b1, 8'h01);
        tests_run++;
        if ({out_valid, locked, code_err, step_err, lap_count, err_count} !== 20'd0) begin
            tests_failed++;
            $display("FAIL clear_state: got v=%b lk=%b ce=%b se=%b lap=%0d err=%0d required all zero",
                     out_valid, locked, code_err, step_err, lap_count, err_count);
        end
        // Back in HUNT: an arbitrary legal code is taken without a step error.
        cyc(1'b0, 1'b1, 8'h02);
        tests_run++;
        if ({out_valid, out_index, locked, step_err, err_count} !== {1'b1, 3'd1, 1'b0, 1'b0, 8'd0}) begin
            tests_failed++;
            $display("FAIL clear_hunt: got v=%b idx=%0d lk=%b se=%b err=%0d required v=1 idx=1 lk=0 se=0 err=0",
                     out_valid, out_index, locked, step_err, err_count);
        end
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 255; i++) cyc(1'b0, 1'b1, 8'h00);
        tests_run++;
        if (err_count !== 8'd255) begin
            tests_failed++;
            $display("FAIL sat_reach: got %0d required 255", err_count);
        end
        for (int i = 0; i < 20; i++) cyc(1'b0, 1'b1, 8'h00);
        tests_run++;
        if ({err_count, code_err} !== {8'd255, 1'b1}) begin
            tests_failed++;
            $display("FAIL sat_hold: got err=%0d ce=%b required err=255 ce=1", err_count, code_err);
        end
    endtask

    task automatic test_async_reset();
        cyc(1'b0, 1'b1, 8'h01);
        cyc(1'b0, 1'b1, 8'h02);
        cyc(1'b0, 1'b1, 8'h04);
        cyc(1'b0, 1'b1, 8'h08);
        tests_run++;
        if ({locked, out_index, lap_count} !== {1'b1, 3'd3, 8'd0}) begin
            tests_failed++;
            $display("FAIL areset_pre: got lk=%b idx=%0d lap=%0d required lk=1 idx=3 lap=0",
                     locked, out_index, lap_count);
        end
        @(negedge clk);
        bus.in_code = 8'h10;
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({out_valid, out_index, locked, code_err, step_err, lap_count, err_count} !== 23'd0) begin
            tests_failed++;
            $display("FAIL areset_mid: got %b/%0d/%b/%b/%b/%0d/%0d required all zero",
                     out_valid, out_index, locked, code_err, step_err, lap_count, err_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        bus.in_valid = 1'b0;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_lock();
        test_laps();
        test_illegal();
        test_flywheel();
        test_gaps();
        test_clear();
        test_saturate();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
